// File: rtl/id_operand_unit_pkg.sv
// Shared constants and operand-source encoding for the ID operand/hazard unit.
package id_operand_unit_pkg;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'd0;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;

    typedef enum logic [2:0] {
        SRC_IMM,
        SRC_ZERO,
        SRC_FWD,
        SRC_WB,
        SRC_HAZ,
        SRC_RF
    } op_src_t;

endpackage

// File: rtl/id_operand_unit_if.sv
// Decoder / pipeline-side bundle of the ID operand unit; master drives requests, slave resolves.
interface id_operand_unit_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
);
    logic                      rs_read;
    logic [ADDR_W-1:0]         rs_addr;
    logic                      rt_read;
    logic [ADDR_W-1:0]         rt_addr;
    logic [DATA_W-1:0]         imm;
    logic [DATA_W-1:0]         rs_data;
    logic [DATA_W-1:0]         rt_data;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD-1:0]        fwd_rdy;
    logic [NUM_FWD*ADDR_W-1:0] fwd_addr;
    logic [NUM_FWD*DATA_W-1:0] fwd_data;
    logic                      issue;
    logic                      flush;
    logic                      dest_long;
    logic [ADDR_W-1:0]         dest_addr;
    logic                      wb_done;
    logic [ADDR_W-1:0]         wb_addr;
    logic [DATA_W-1:0]         wb_data;
    logic [DATA_W-1:0]         reg1;
    logic [DATA_W-1:0]         reg2;
    logic                      stallreq;
    logic [CNT_W-1:0]          stall_cnt;

    modport master (
        output rs_read, rs_addr, rt_read, rt_addr, imm, rs_data, rt_data,
               fwd_we, fwd_rdy, fwd_addr, fwd_data, issue, flush,
               dest_long, dest_addr, wb_done, wb_addr, wb_data,
        input  reg1, reg2, stallreq, stall_cnt
    );

    modport slave (
        input  rs_read, rs_addr, rt_read, rt_addr, imm, rs_data, rt_data,
               fwd_we, fwd_rdy, fwd_addr, fwd_data, issue, flush,
               dest_long, dest_addr, wb_done, wb_addr, wb_data,
        output reg1, reg2, stallreq, stall_cnt
    );

endinterface

// File: rtl/id_fwd_mux.sv
// Per-operand source selection: forwarding, long-op bypass, scoreboard hazard, regfile or immediate.
module id_fwd_mux
    import id_operand_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2,
    parameter int PEND_W  = 2
) (
    input  logic                      read,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         imm,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_we,
    input  logic [NUM_FWD-1:0]        fwd_rdy,
    input  logic [NUM_FWD*ADDR_W-1:0] fwd_addr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      wb_done,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic [PEND_W-1:0]         pend_cnt,
    output logic [DATA_W-1:0]         operand,
    output logic                      hazard
);

    logic [NUM_FWD-1:0] match;
    logic               hit;
    logic               hit_rdy;
    logic [DATA_W-1:0]  hit_data;
    op_src_t            src;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign match[gi] = fwd_we[gi] && (fwd_addr[gi*ADDR_W +: ADDR_W] == addr);
        end
    endgenerate

    // Scan oldest to youngest so the lowest matching index overrides.
    always_comb begin
        hit      = 1'b0;
        hit_rdy  = 1'b0;
        hit_data = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit      = 1'b1;
                hit_rdy  = fwd_rdy[i];
                hit_data = fwd_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        src = SRC_RF;
        if (!read)
            src = SRC_IMM;
        else if (addr == '0)
            src = SRC_ZERO;
        else if (hit)
            src = hit_rdy ? SRC_FWD : SRC_HAZ;
        else if (wb_done && (wb_addr == addr) && (pend_cnt == PEND_W'(1)))
            src = SRC_WB;
        else if (pend_cnt != '0)
            src = SRC_HAZ;
    end

    always_comb begin
        operand = '0;
        hazard  = NoStop;
        case (src)
            SRC_IMM: operand = imm;
            SRC_FWD: operand = hit_data;
            SRC_WB:  operand = wb_data;
            SRC_HAZ: hazard  = Stop;
            SRC_RF:  operand = rf_data;
            default: operand = '0;
        endcase
    end

endmodule

// File: rtl/id_operand_unit.sv
// ID-stage operand resolution with a long-latency write scoreboard, stall request and stall counter.
module id_operand_unit
    import id_operand_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_FWD = 2,
    parameter int PEND_W  = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    id_operand_unit_if.slave bus
);

    localparam int                NREG     = 2 ** ADDR_W;
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] pend_reg  [NREG];
    logic [PEND_W-1:0] pend_next [NREG];
    logic [CNT_W-1:0]  stall_cnt_reg;

    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic              haz1;
    logic              haz2;
    logic              cap_stall;
    logic              stall;
    logic              fire;
    logic              sb_set;
    logic              sb_clr;

    id_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .PEND_W(PEND_W)) u_mux_rs (
        .read(bus.rs_read), .addr(bus.rs_addr), .imm(bus.imm), .rf_data(bus.rs_data),
        .fwd_we(bus.fwd_we), .fwd_rdy(bus.fwd_rdy), .fwd_addr(bus.fwd_addr), .fwd_data(bus.fwd_data),
        .wb_done(bus.wb_done), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
        .pend_cnt(pend_reg[bus.rs_addr]), .operand(op1), .hazard(haz1)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_FWD(NUM_FWD), .PEND_W(PEND_W)) u_mux_rt (
        .read(bus.rt_read), .addr(bus.rt_addr), .imm(bus.imm), .rf_data(bus.rt_data),
        .fwd_we(bus.fwd_we), .fwd_rdy(bus.fwd_rdy), .fwd_addr(bus.fwd_addr), .fwd_data(bus.fwd_data),
        .wb_done(bus.wb_done), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
        .pend_cnt(pend_reg[bus.rt_addr]), .operand(op2), .hazard(haz2)
    );

    // A full counter cannot absorb another long write, so the issue must wait.
    assign cap_stall = bus.dest_long && (bus.dest_addr != '0) && (pend_reg[bus.dest_addr] == PEND_MAX);
    assign stall     = !rst && bus.issue && !bus.flush && (haz1 || haz2 || cap_stall);
    assign fire      = bus.issue && !bus.flush && !stall;
    assign sb_set    = fire && bus.dest_long && (bus.dest_addr != '0);
    assign sb_clr    = bus.wb_done && (bus.wb_addr != '0);

    assign bus.reg1      = rst ? '0 : op1;
    assign bus.reg2      = rst ? '0 : op2;
    assign bus.stallreq  = stall;
    assign bus.stall_cnt = stall_cnt_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            logic set_hit;
            logic clr_hit;
            assign set_hit = sb_set && (bus.dest_addr == ADDR_W'(gi));
            assign clr_hit = sb_clr && (bus.wb_addr == ADDR_W'(gi));
            assign pend_next[gi] = (set_hit && !clr_hit) ? pend_reg[gi] + PEND_W'(1) :
                                   (clr_hit && !set_hit && pend_reg[gi] != '0) ? pend_reg[gi] - PEND_W'(1) :
                                   pend_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                pend_reg[i] <= '0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_reg <= '0;
        else if (stall && (stall_cnt_reg != {CNT_W{1'b1}}))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end

endmodule
